// File: rtl/conware_pkg.sv
// Shared definitions for the conware board pipeline.
//   feeder_state_e : row_feeder FSM state encoding
//   ShredClrLvl    : level of shred_rstn that clears the shredders
//   ShredRunLvl    : level of shred_rstn while the shredders run normally
package conware_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFetch,
      StWait,
      StPush,
      StPad,
      StFinish
   } feeder_state_e;

   localparam logic ShredClrLvl = 1'b0;
   localparam logic ShredRunLvl = ~ShredClrLvl;

endpackage

// File: rtl/result_tracker.sv
// Result tracker: counts shredder shift strobes within a frame and flags which
// board row the shredder next_state outputs hold.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the strobe count at the top of a frame
//   strobe    : shift strobe issued to the shredders this cycle
//   res_valid : shredder outputs hold board row res_row this cycle
//   res_row   : board row index of the current result
module result_tracker #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              strobe,
   output logic              res_valid,
   output logic [ADDR_W-1:0] res_row
);

   // One extra bit: the count reaches ROWS+1, which can exceed the row-address range.
   localparam int unsigned CntW = ADDR_W + 1;

   logic [CntW-1:0]   k_q, k_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] row_q, row_d;

   // k_q holds the number of strobes seen so far; the strobe that makes it k (k>=2)
   // completes the 3-row window centred on row k-2, valid the following cycle.
   always_comb begin
      k_d     = k_q;
      valid_d = 1'b0;
      row_d   = row_q;
      if (clr) begin
         k_d = '0;
      end else if (strobe) begin
         k_d = k_q + CntW'(1);
         if (k_q != '0) begin
            valid_d = 1'b1;
            row_d   = ADDR_W'(k_q - CntW'(1));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q     <= '0;
         valid_q <= 1'b0;
         row_q   <= '0;
      end else begin
         k_q     <= k_d;
         valid_q <= valid_d;
         row_q   <= row_d;
      end
   end

   assign res_valid = valid_q;
   assign res_row   = row_q;

endmodule

// File: rtl/row_feeder.sv
// Row feeder: streams one frame of board rows from memory into a bank of
// per-column shredders, appends one trailing zero row, and reports which
// board row each shredder result belongs to.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request one frame (honoured only when idle)
//   busy, done          : frame in progress / one-cycle completion pulse
//   mem_rd, mem_addr    : row read request and row index (held until mem_rvalid)
//   mem_rvalid, mem_rdata : read response, one board row
//   out_ready           : downstream can accept a result row next cycle
//   shred_rstn          : synchronous active-low shredder clear
//   din_row, shred_en   : row shifted into the shredders and its strobe
//   res_valid, res_row  : shredder result valid and its board row index
module row_feeder
   import conware_pkg::*;
#(
   parameter int unsigned COLS   = 32,
   parameter int unsigned ROWS   = 32,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [COLS-1:0]   mem_rdata,
   input  logic              out_ready,
   output logic              shred_rstn,
   output logic [COLS-1:0]   din_row,
   output logic              shred_en,
   output logic              res_valid,
   output logic [ADDR_W-1:0] res_row
);

   localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(ROWS - 1);

   feeder_state_e     state_q, state_d;
   logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
   logic [COLS-1:0]   row_reg_q, row_reg_d;
   logic              trk_clr;

   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      row_reg_d  = row_reg_q;
      trk_clr    = 1'b0;
      busy       = (state_q != StIdle);
      done       = 1'b0;
      mem_rd     = 1'b0;
      shred_rstn = ShredRunLvl;
      shred_en   = 1'b0;
      din_row    = '0;

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StClear;
         end
         // Clearing the shredders gives the zero boundary above row 0.
         StClear: begin
            shred_rstn = ShredClrLvl;
            row_cnt_d  = '0;
            trk_clr    = 1'b1;
            state_d    = StFetch;
         end
         StFetch: begin
            mem_rd  = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            if (mem_rvalid) begin
               row_reg_d = mem_rdata;
               state_d   = StPush;
            end
         end
         StPush: begin
            if (out_ready) begin
               shred_en = 1'b1;
               din_row  = row_reg_q;
               if (row_cnt_q == LastRow) begin
                  state_d = StPad;
               end else begin
                  row_cnt_d = row_cnt_q + ADDR_W'(1);
                  state_d   = StFetch;
               end
            end
         end
         // Trailing zero row: the boundary below the last board row, no memory read.
         StPad: begin
            if (out_ready) begin
               shred_en = 1'b1;
               state_d  = StFinish;
            end
         end
         StFinish: begin
            if (res_valid) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         row_cnt_q <= '0;
         row_reg_q <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         row_reg_q <= row_reg_d;
      end
   end

   assign mem_addr = row_cnt_q;

   result_tracker #(
      .ADDR_W (ADDR_W)
   ) u_result_tracker (
      .clk       (clk),
      .rst       (rst),
      .clr       (trk_clr),
      .strobe    (shred_en),
      .res_valid (res_valid),
      .res_row   (res_row)
   );

endmodule

// File: tb/tb_row_feeder.sv
// Bench for row_feeder with ROWS=4, COLS=8: a table of frames with hand-derived
// next-generation results, a behavioural memory and shredder bank, and a
// scoreboard of expected results popped on each res_valid.
module tb_row_feeder;

   localparam int unsigned COLS   = 8;
   localparam int unsigned ROWS   = 4;
   localparam int unsigned ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, mem_rd, shred_rstn, shred_en, res_valid;
   logic [ADDR_W-1:0] mem_addr, res_row;
   logic              mem_rvalid = 1'b0;
   logic [COLS-1:0]   mem_rdata = '0;
   logic              out_ready = 1'b1;
   logic [COLS-1:0]   din_row;

   row_feeder #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .out_ready  (out_ready),
      .shred_rstn (shred_rstn),
      .din_row    (din_row),
      .shred_en   (shred_en),
      .res_valid  (res_valid),
      .res_row    (res_row)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [3:0][7:0] rows;
      int              lat;
      int              stall_row;
      bit              poke;
      logic [3:0][7:0] exp;
   } vec_t;

   typedef struct {
      int         row;
      logic [7:0] val;
   } exp_t;

   vec_t            vecs[6];
   exp_t            sb[$];
   logic [3:0][7:0] mem = '0;
   int              lat = 1;
   int              stall_row = -1;
   int              n_vec = 0;
   int              n_miss = 0;
   int              strobes = 0;
   int              clears = 0;
   int              dones = 0;
   logic [7:0]      win_a = '0, win_m = '0, win_b = '0;
   bit              pending = 1'b0;
   logic [7:0]      pend_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One Game-of-Life generation of the middle row, cells beyond the edges dead.
   function automatic logic [7:0] life(input logic [7:0] a, input logic [7:0] m,
                                       input logic [7:0] b);
      logic [9:0] pa, pm, pb;
      logic [7:0] r;
      int         n;
      pa = {1'b0, a, 1'b0};
      pm = {1'b0, m, 1'b0};
      pb = {1'b0, b, 1'b0};
      r  = '0;
      for (int c = 0; c < 8; c++) begin
         n = int'(pa[c]) + int'(pa[c+1]) + int'(pa[c+2]) + int'(pm[c]) + int'(pm[c+2])
           + int'(pb[c]) + int'(pb[c+1]) + int'(pb[c+2]);
         r[c] = (n == 3) || (pm[c+1] && n == 2);
      end
      return r;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_mem_rd"}, mem_rd, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_shred_en"}, shred_en, 0);
      check({tag, "_din_row"}, din_row, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_row"}, res_row, 0);
      check({tag, "_shred_rstn"}, shred_rstn, 1);
   endtask

   // Memory: answers each read after lat cycles; optionally stalls downstream
   // for the five cycles after a chosen row arrives.
   initial begin : responder
      logic [7:0] a;
      forever begin
         @(negedge clk);
         if (mem_rd && !rst) begin
            a = mem_addr;
            repeat (lat) @(posedge clk);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = mem[a[1:0]];
            if (int'(a) == stall_row) out_ready = 1'b0;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (!out_ready) begin
               repeat (5) @(posedge clk);
               #1;
               out_ready = 1'b1;
            end
         end
      end
   end

   // Monitor and shredder-bank model, sampled on the falling edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            pending = 1'b0;
         end else begin
            if (!shred_en) check("din_zero_when_idle", din_row, 0);
            if (shred_en) check("strobe_needs_ready", out_ready, 1);
            if (pending) begin
               check("no_second_rd", mem_rd, 0);
               check("addr_stable", mem_addr, pend_addr);
            end
            if (mem_rvalid) pending = 1'b0;
            if (mem_rd) begin
               check("addr_in_range", 32'(mem_addr < ROWS), 1);
               pending   = 1'b1;
               pend_addr = mem_addr;
            end
            if (res_valid) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL sb_underflow: res_valid row %0d, nothing expected", res_row);
               end else begin
                  e = sb.pop_front();
                  check("res_row", res_row, e.row);
                  check("next_state", life(win_a, win_m, win_b), e.val);
               end
            end
            if (!shred_rstn) begin
               clears++;
               win_a = '0;
               win_m = '0;
               win_b = '0;
            end
            if (shred_en) begin
               strobes++;
               win_a = win_m;
               win_m = win_b;
               win_b = din_row;
            end
            if (done) dones++;
         end
      end
   end

   task automatic run_frame(input vec_t v);
      int t;
      mem       = v.rows;
      lat       = v.lat;
      stall_row = v.stall_row;
      for (int r = 0; r < int'(ROWS); r++) sb.push_back('{r, v.exp[r]});
      strobes = 0;
      clears  = 0;
      dones   = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({v.name, "_busy_after_start"}, busy, 1);
      if (v.poke) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      t = 0;
      while (!done && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s_done_timeout: no done within 300 cycles", v.name);
      end
      // A start coinciding with done must not launch another frame.
      if (v.poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({v.name, "_busy_after_done"}, busy, 0);
      repeat (3) @(negedge clk);
      check({v.name, "_still_idle"}, busy, 0);
      check({v.name, "_done_count"}, dones, 1);
      check({v.name, "_strobes"}, strobes, ROWS + 1);
      check({v.name, "_clear_cycles"}, clears, 1);
      check({v.name, "_sb_drained"}, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      vecs[0] = '{name: "blinker", rows: 32'h00001C00, lat: 1, stall_row: -1, poke: 0,
                  exp: 32'h00080808};
      vecs[1] = '{name: "blinker_lat3", rows: 32'h00001C00, lat: 3, stall_row: -1, poke: 0,
                  exp: 32'h00080808};
      vecs[2] = '{name: "stall_row2", rows: 32'h00001C00, lat: 1, stall_row: 2, poke: 0,
                  exp: 32'h00080808};
      vecs[3] = '{name: "all_ones", rows: 32'hFFFFFFFF, lat: 2, stall_row: -1, poke: 0,
                  exp: 32'h81000081};
      vecs[4] = '{name: "block_poke", rows: 32'h00000606, lat: 1, stall_row: -1, poke: 1,
                  exp: 32'h00000606};
      vecs[5] = '{name: "vblink_edge", rows: 32'h00010101, lat: 2, stall_row: 3, poke: 0,
                  exp: 32'h00000300};

      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("idle");

      foreach (vecs[i]) run_frame(vecs[i]);

      // Abort in WAIT; the late read response must be ignored.
      mem       = vecs[0].rows;
      lat       = 3;
      stall_row = -1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!mem_rd && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("abort_saw_rd", mem_rd, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals("abort_in_rst");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_reset_vals("abort_after");
      end
      sb.delete();
      run_frame(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/row_feeder.md
ROW_FEEDER -- requirements
Module: row_feeder

Interface
REQ-001 SHALL have parameter COLS, default 32, number of board columns (one shredder per column).
REQ-002 SHALL have parameter ROWS, default 32, number of board rows per frame, legal range 2..256.
REQ-003 SHALL have parameter ADDR_W, default 8, row-address width; ROWS-1 SHALL fit in ADDR_W bits.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to process one frame; ignored unless idle.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  one-cycle pulse after the final result row is flagged.
REQ-009 mem_rd  out  1  one-cycle row read request.
REQ-010 mem_addr  out  ADDR_W  row index being read, held stable until mem_rvalid.
REQ-011 mem_rvalid  in  1  mem_rdata valid this cycle; arrives 1..N cycles after mem_rd.
REQ-012 mem_rdata  in  COLS  one board row; bit c = cell of column c.
REQ-013 out_ready  in  1  downstream row writer can accept a result row next cycle.
REQ-014 shred_rstn  out  1  active-low synchronous clear to all shredders.
REQ-015 din_row  out  COLS  per-column din to shredders.
REQ-016 shred_en  out  1  shift strobe common to all shredders.
REQ-017 res_valid  out  1  shredder next_state outputs hold board row res_row this cycle.
REQ-018 res_row  out  ADDR_W  board row index of the current result.

Function
REQ-019 States SHALL be IDLE, CLEAR, FETCH, WAIT, PUSH, PAD, FINISH.
REQ-020 IDLE + start -> CLEAR; CLEAR drives shred_rstn=0 for exactly one cycle, resets row counter to 0 and shift counter to 0, -> FETCH.
REQ-021 FETCH SHALL pulse mem_rd with mem_addr=row counter for one cycle, -> WAIT.
REQ-022 WAIT SHALL capture mem_rdata into a COLS-bit row register on mem_rvalid, -> PUSH; mem_rvalid outside WAIT SHALL be ignored.
REQ-023 PUSH SHALL drive din_row=row register and assert shred_en for exactly one cycle, only in a cycle with out_ready=1; otherwise it holds with shred_en=0.
REQ-024 After a PUSH strobe: if row counter=ROWS-1 -> PAD, else increment row counter -> FETCH.
REQ-025 PAD SHALL drive din_row=0 and one shred_en strobe gated by out_ready exactly as PUSH, then -> FINISH.
REQ-026 Total shred_en strobes per frame SHALL be ROWS+1 (ROWS data rows plus one trailing zero row); no leading pad row, CLEAR supplies the top zero boundary.
REQ-027 Shift counter k SHALL count strobes 1..ROWS+1; for every strobe with k>=2, res_valid SHALL be high in the following cycle with res_row=k-2.
REQ-028 FINISH SHALL wait for the last res_valid, pulse done for one cycle, -> IDLE; busy falls with done.
REQ-029 din_row SHALL be 0 whenever shred_en=0.
REQ-030 start while busy SHALL have no effect; start in the same cycle as done SHALL be ignored.
REQ-031 mem_addr SHALL never exceed ROWS-1; no read is issued for the pad row.

Reset
REQ-032 On rst: state IDLE, counters 0, row register 0, busy=0, done=0, mem_rd=0, mem_addr=0, shred_en=0, din_row=0, res_valid=0, res_row=0, shred_rstn=1.
REQ-033 rst mid-frame SHALL abort immediately; a pending mem_rvalid after rst deasserts SHALL be ignored; the next start begins with CLEAR.

Structure
REQ-034 State encoding and the shredder-clear polarity constant SHALL live in the shared conware package.
REQ-035 Single flat module; the result tracker (shift counter -> res_valid/res_row) MAY be a sub-module named result_tracker.

Verification
REQ-036 ROWS=4, COLS=8, 1-cycle memory, out_ready=1, rows 0x00,0x1C,0x00,0x00 -> 5 strobes, res_valid for rows 0..3, shredder outputs row1=0x08, rows0/2=0x08, row3=0x00, done once.
REQ-037 Memory latency 3 cycles -> mem_addr held stable through WAIT, no second mem_rd before rvalid, same results as REQ-036.
REQ-038 out_ready low 5 cycles during PUSH of row 2 -> no shred_en, din_row=0 while stalled, single strobe when released.
REQ-039 start pulsed while busy and on done cycle -> exactly one frame processed, one done pulse.
REQ-040 rst asserted in WAIT, stale mem_rvalid after release -> outputs at reset values, FSM stays IDLE; next start gives shred_rstn=0 one cycle then correct frame.
REQ-041 ROWS=2, all-ones rows -> 3 strobes, res_row 0 then 1, last din_row=0.
